// File: rtl/gpc207_4_accum.sv
// Streaming frame accumulator behind a (2,0,7;4) generalized parallel counter.
// Each beat is reduced to a 0..15 weight and summed per frame with saturation.

module gpc207_4 (
   input  logic [6:0] src0,
   input  logic [1:0] src2,
   output logic [3:0] dst
);

   // NOTE: assign a default first in every always_comb so no path can infer a latch.
   always_comb begin
      dst = '0;
      for (int i = 0; i < 7; i++) begin
         dst = dst + 4'(src0[i]);
      end
      dst = dst + (4'(src2[0]) << 2) + (4'(src2[1]) << 2);
   end

endmodule

module gpc207_4_accum #(
   parameter int ACC_WIDTH = 16,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [6:0]           in_src0,
   input  logic [1:0]           in_src2,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_sum,
   output logic [CNT_WIDTH-1:0] out_count,
   output logic                 out_overflow
);

   logic [3:0]           gpc_dst;
   logic                 s1_valid;
   logic [3:0]           s1_dst;
   logic                 s1_last;
   logic                 s1_advance;
   logic                 accept;

   logic [ACC_WIDTH-1:0] acc;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 ovf;

   logic [ACC_WIDTH:0]   sum_ext;
   logic [CNT_WIDTH:0]   cnt_ext;
   logic [ACC_WIDTH-1:0] sum_new;
   logic [CNT_WIDTH-1:0] cnt_new;
   logic                 ovf_new;

   gpc207_4 u_gpc (
      .src0 (in_src0),
      .src2 (in_src2),
      .dst  (gpc_dst)
   );

   // A last beat may only leave S1 when the output register is free or draining.
   assign s1_advance = s1_valid && (!s1_last || !out_valid || out_ready);
   assign in_ready   = !s1_valid || s1_advance;
   assign accept     = in_valid && in_ready;

   assign sum_ext = {1'b0, acc} + {{(ACC_WIDTH-3){1'b0}}, s1_dst};
   assign cnt_ext = {1'b0, cnt} + {{CNT_WIDTH{1'b0}}, 1'b1};
   assign sum_new = sum_ext[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_ext[ACC_WIDTH-1:0];
   assign cnt_new = cnt_ext[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : cnt_ext[CNT_WIDTH-1:0];
   assign ovf_new = ovf | sum_ext[ACC_WIDTH] | cnt_ext[CNT_WIDTH];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_dst   <= '0;
         s1_last  <= 1'b0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_dst   <= gpc_dst;
         s1_last  <= in_last;
      end else if (s1_advance) begin
         s1_valid <= 1'b0;
      end
   end

   // The accumulator clears on the same edge a frame's last beat leaves, so frames abut.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (s1_advance) begin
         if (s1_last) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
         end else begin
            acc <= sum_new;
            cnt <= cnt_new;
            ovf <= ovf_new;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid    <= 1'b0;
         out_sum      <= '0;
         out_count    <= '0;
         out_overflow <= 1'b0;
      end else if (s1_advance && s1_last) begin
         out_valid    <= 1'b1;
         out_sum      <= sum_new;
         out_count    <= cnt_new;
         out_overflow <= ovf_new;
      end else if (out_ready) begin
         out_valid    <= 1'b0;
      end
   end

endmodule
